// File: rtl/riscv_tracer_defines.sv
// Shared tracer definitions: opcode/instruction masks, instruction classes and
// the retired-record layout captured ahead of the instruction tracer.
package riscv_tracer_defines;

  localparam logic [6:0] OPCODE_SYSTEM   = 7'h73;
  localparam logic [6:0] OPCODE_FENCE    = 7'h0f;
  localparam logic [6:0] OPCODE_OP       = 7'h33;
  localparam logic [6:0] OPCODE_OPIMM    = 7'h13;
  localparam logic [6:0] OPCODE_STORE    = 7'h23;
  localparam logic [6:0] OPCODE_LOAD     = 7'h03;
  localparam logic [6:0] OPCODE_BRANCH   = 7'h63;
  localparam logic [6:0] OPCODE_JALR     = 7'h67;
  localparam logic [6:0] OPCODE_JAL      = 7'h6f;
  localparam logic [6:0] OPCODE_AUIPC    = 7'h17;
  localparam logic [6:0] OPCODE_LUI      = 7'h37;
  localparam logic [6:0] OPCODE_OP_FP    = 7'h53;
  localparam logic [6:0] OPCODE_FMADD    = 7'h43;
  localparam logic [6:0] OPCODE_FMSUB    = 7'h47;
  localparam logic [6:0] OPCODE_FNMSUB   = 7'h4b;
  localparam logic [6:0] OPCODE_FNMADD   = 7'h4f;
  localparam logic [6:0] OPCODE_STORE_FP = 7'h27;
  localparam logic [6:0] OPCODE_LOAD_FP  = 7'h07;
  localparam logic [6:0] OPCODE_AMO      = 7'h2f;

  localparam logic [31:0] INSTR_LUI    = {25'b?, OPCODE_LUI};
  localparam logic [31:0] INSTR_AUIPC  = {25'b?, OPCODE_AUIPC};
  localparam logic [31:0] INSTR_JAL    = {25'b?, OPCODE_JAL};
  localparam logic [31:0] INSTR_JALR   = {17'b?, 3'b000, 5'b?, OPCODE_JALR};

  localparam logic [31:0] INSTR_BEQ    = {17'b?, 3'b000, 5'b?, OPCODE_BRANCH};
  localparam logic [31:0] INSTR_BNE    = {17'b?, 3'b001, 5'b?, OPCODE_BRANCH};
  localparam logic [31:0] INSTR_BEQIMM = {17'b?, 3'b010, 5'b?, OPCODE_BRANCH};
  localparam logic [31:0] INSTR_BNEIMM = {17'b?, 3'b011, 5'b?, OPCODE_BRANCH};
  localparam logic [31:0] INSTR_BLT    = {17'b?, 3'b100, 5'b?, OPCODE_BRANCH};
  localparam logic [31:0] INSTR_BGE    = {17'b?, 3'b101, 5'b?, OPCODE_BRANCH};
  localparam logic [31:0] INSTR_BLTU   = {17'b?, 3'b110, 5'b?, OPCODE_BRANCH};
  localparam logic [31:0] INSTR_BGEU   = {17'b?, 3'b111, 5'b?, OPCODE_BRANCH};

  localparam logic [31:0] INSTR_LB     = {17'b?, 3'b000, 5'b?, OPCODE_LOAD};
  localparam logic [31:0] INSTR_LH     = {17'b?, 3'b001, 5'b?, OPCODE_LOAD};
  localparam logic [31:0] INSTR_LW     = {17'b?, 3'b010, 5'b?, OPCODE_LOAD};
  localparam logic [31:0] INSTR_LBU    = {17'b?, 3'b100, 5'b?, OPCODE_LOAD};
  localparam logic [31:0] INSTR_LHU    = {17'b?, 3'b101, 5'b?, OPCODE_LOAD};
  localparam logic [31:0] INSTR_SB     = {17'b?, 3'b000, 5'b?, OPCODE_STORE};
  localparam logic [31:0] INSTR_SH     = {17'b?, 3'b001, 5'b?, OPCODE_STORE};
  localparam logic [31:0] INSTR_SW     = {17'b?, 3'b010, 5'b?, OPCODE_STORE};

  localparam logic [31:0] INSTR_MUL    = {7'b0000001, 10'b?, 3'b000, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_MULH   = {7'b0000001, 10'b?, 3'b001, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_MULHSU = {7'b0000001, 10'b?, 3'b010, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_MULHU  = {7'b0000001, 10'b?, 3'b011, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_DIV    = {7'b0000001, 10'b?, 3'b100, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_DIVU   = {7'b0000001, 10'b?, 3'b101, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_REM    = {7'b0000001, 10'b?, 3'b110, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_REMU   = {7'b0000001, 10'b?, 3'b111, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PMAC   = {7'b0100001, 10'b?, 3'b000, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PMSU   = {7'b0100001, 10'b?, 3'b001, 5'b?, OPCODE_OP};

  localparam logic [31:0] INSTR_FF1    = {7'b0001000, 10'b?, 3'b000, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_FL1    = {7'b0001000, 10'b?, 3'b001, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_CLB    = {7'b0001000, 10'b?, 3'b010, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_CNT    = {7'b0001000, 10'b?, 3'b011, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_EXTHS  = {7'b0001000, 10'b?, 3'b100, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_EXTHZ  = {7'b0001000, 10'b?, 3'b101, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_EXTBS  = {7'b0001000, 10'b?, 3'b110, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_EXTBZ  = {7'b0001000, 10'b?, 3'b111, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PAVG   = {7'b0000010, 10'b?, 3'b000, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PAVGU  = {7'b0000010, 10'b?, 3'b001, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PSLET  = {7'b0000010, 10'b?, 3'b010, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PSLETU = {7'b0000010, 10'b?, 3'b011, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PMIN   = {7'b0000010, 10'b?, 3'b100, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PMINU  = {7'b0000010, 10'b?, 3'b101, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PMAX   = {7'b0000010, 10'b?, 3'b110, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PMAXU  = {7'b0000010, 10'b?, 3'b111, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_ROR    = {7'b0000100, 10'b?, 3'b101, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PABS   = {7'b0001010, 10'b?, 3'b000, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_CLIP   = {7'b0001010, 10'b?, 3'b001, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_CLIPU  = {7'b0001010, 10'b?, 3'b010, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PBEXT  = {2'b11, 15'b?, 3'b000, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PBEXTU = {2'b11, 15'b?, 3'b001, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PBINS  = {2'b11, 15'b?, 3'b010, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PBCLR  = {2'b11, 15'b?, 3'b011, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PBSET  = {2'b11, 15'b?, 3'b100, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PBEXTR = {7'b1000000, 10'b?, 3'b000, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PBEXTUR = {7'b1000000, 10'b?, 3'b001, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PBINSR = {7'b1000000, 10'b?, 3'b010, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PBCLRR = {7'b1000000, 10'b?, 3'b011, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_PBSETR = {7'b1000000, 10'b?, 3'b100, 5'b?, OPCODE_OP};

  localparam logic [31:0] INSTR_ADD    = {7'b0000000, 10'b?, 3'b000, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_SUB    = {7'b0100000, 10'b?, 3'b000, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_SLL    = {7'b0000000, 10'b?, 3'b001, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_SLT    = {7'b0000000, 10'b?, 3'b010, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_SLTU   = {7'b0000000, 10'b?, 3'b011, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_XOR    = {7'b0000000, 10'b?, 3'b100, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_SRL    = {7'b0000000, 10'b?, 3'b101, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_SRA    = {7'b0100000, 10'b?, 3'b101, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_OR     = {7'b0000000, 10'b?, 3'b110, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_AND    = {7'b0000000, 10'b?, 3'b111, 5'b?, OPCODE_OP};
  localparam logic [31:0] INSTR_ADDI   = {17'b?, 3'b000, 5'b?, OPCODE_OPIMM};
  localparam logic [31:0] INSTR_SLTI   = {17'b?, 3'b010, 5'b?, OPCODE_OPIMM};
  localparam logic [31:0] INSTR_SLTIU  = {17'b?, 3'b011, 5'b?, OPCODE_OPIMM};
  localparam logic [31:0] INSTR_XORI   = {17'b?, 3'b100, 5'b?, OPCODE_OPIMM};
  localparam logic [31:0] INSTR_ORI    = {17'b?, 3'b110, 5'b?, OPCODE_OPIMM};
  localparam logic [31:0] INSTR_ANDI   = {17'b?, 3'b111, 5'b?, OPCODE_OPIMM};
  localparam logic [31:0] INSTR_SLLI   = {7'b0000000, 10'b?, 3'b001, 5'b?, OPCODE_OPIMM};
  localparam logic [31:0] INSTR_SRLI   = {7'b0000000, 10'b?, 3'b101, 5'b?, OPCODE_OPIMM};
  localparam logic [31:0] INSTR_SRAI   = {7'b0100000, 10'b?, 3'b101, 5'b?, OPCODE_OPIMM};

  localparam logic [31:0] INSTR_CSRRW  = {17'b?, 3'b001, 5'b?, OPCODE_SYSTEM};
  localparam logic [31:0] INSTR_CSRRS  = {17'b?, 3'b010, 5'b?, OPCODE_SYSTEM};
  localparam logic [31:0] INSTR_CSRRC  = {17'b?, 3'b011, 5'b?, OPCODE_SYSTEM};
  localparam logic [31:0] INSTR_CSRRWI = {17'b?, 3'b101, 5'b?, OPCODE_SYSTEM};
  localparam logic [31:0] INSTR_CSRRSI = {17'b?, 3'b110, 5'b?, OPCODE_SYSTEM};
  localparam logic [31:0] INSTR_CSRRCI = {17'b?, 3'b111, 5'b?, OPCODE_SYSTEM};
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_URET   = 32'h0020_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
  localparam logic [31:0] INSTR_DRET   = 32'h7B20_0073;
  localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;
  localparam logic [31:0] INSTR_FENCE  = {17'b?, 3'b000, 5'b?, OPCODE_FENCE};
  localparam logic [31:0] INSTR_FENCEI = {17'b?, 3'b001, 5'b?, OPCODE_FENCE};

  localparam logic [31:0] INSTR_FLW    = {17'b?, 3'b010, 5'b?, OPCODE_LOAD_FP};
  localparam logic [31:0] INSTR_FSW    = {17'b?, 3'b010, 5'b?, OPCODE_STORE_FP};
  localparam logic [31:0] INSTR_FMADD  = {5'b?, 2'b00, 18'b?, OPCODE_FMADD};
  localparam logic [31:0] INSTR_FMSUB  = {5'b?, 2'b00, 18'b?, OPCODE_FMSUB};
  localparam logic [31:0] INSTR_FNMSUB = {5'b?, 2'b00, 18'b?, OPCODE_FNMSUB};
  localparam logic [31:0] INSTR_FNMADD = {5'b?, 2'b00, 18'b?, OPCODE_FNMADD};
  localparam logic [31:0] INSTR_FOP_S  = {5'b?, 2'b00, 18'b?, OPCODE_OP_FP};

  localparam logic [31:0] INSTR_LR     = {5'b00010, 2'b?, 5'b00000, 5'b?, 3'b010, 5'b?, OPCODE_AMO};
  localparam logic [31:0] INSTR_SC     = {5'b00011, 2'b?, 10'b?, 3'b010, 5'b?, OPCODE_AMO};
  localparam logic [31:0] INSTR_AMOSWAP = {5'b00001, 2'b?, 10'b?, 3'b010, 5'b?, OPCODE_AMO};
  localparam logic [31:0] INSTR_AMOADD = {5'b00000, 2'b?, 10'b?, 3'b010, 5'b?, OPCODE_AMO};
  localparam logic [31:0] INSTR_AMOXOR = {5'b00100, 2'b?, 10'b?, 3'b010, 5'b?, OPCODE_AMO};
  localparam logic [31:0] INSTR_AMOAND = {5'b01100, 2'b?, 10'b?, 3'b010, 5'b?, OPCODE_AMO};
  localparam logic [31:0] INSTR_AMOOR  = {5'b01000, 2'b?, 10'b?, 3'b010, 5'b?, OPCODE_AMO};
  localparam logic [31:0] INSTR_AMOMIN = {5'b10000, 2'b?, 10'b?, 3'b010, 5'b?, OPCODE_AMO};
  localparam logic [31:0] INSTR_AMOMAX = {5'b10100, 2'b?, 10'b?, 3'b010, 5'b?, OPCODE_AMO};
  localparam logic [31:0] INSTR_AMOMINU = {5'b11000, 2'b?, 10'b?, 3'b010, 5'b?, OPCODE_AMO};
  localparam logic [31:0] INSTR_AMOMAXU = {5'b11100, 2'b?, 10'b?, 3'b010, 5'b?, OPCODE_AMO};

  // Stored sequence field width; collectors use CNT_WIDTH <= TRACE_SEQ_W.
  localparam int unsigned TRACE_SEQ_W = 16;

  typedef enum logic [3:0] {
    TC_NONE     = 4'd0,
    TC_UPPER    = 4'd1,
    TC_JUMP     = 4'd2,
    TC_BRANCH   = 4'd3,
    TC_LOAD     = 4'd4,
    TC_STORE    = 4'd5,
    TC_MULDIV   = 4'd6,
    TC_PULP_ALU = 4'd7,
    TC_ALU      = 4'd8,
    TC_CSR      = 4'd9,
    TC_SYSTEM   = 4'd10,
    TC_FENCE    = 4'd11,
    TC_FP       = 4'd12,
    TC_ATOMIC   = 4'd13
  } trace_class_e;

  typedef struct packed {
    logic [31:0]            pc;
    logic [31:0]            instr;
    logic                   compressed;
    trace_class_e           instr_class;
    logic                   rd_we;
    logic [5:0]             rd_addr;
    logic [31:0]            rd_wdata;
    logic [TRACE_SEQ_W-1:0] seq;
  } trace_rec_t;

endpackage

// File: rtl/riscv_trace_classify.sv
// Combinational instruction classifier: first matching tracer mask wins.
module riscv_trace_classify
  import riscv_tracer_defines::*;
(
  input  logic [31:0]  instr,
  output trace_class_e instr_class
);

  // PULP masks share OPCODE_OP with the base ALU ops, so they must come first.
  always_comb begin
    instr_class = TC_NONE;
    casez (instr)
      INSTR_LUI, INSTR_AUIPC:
        instr_class = TC_UPPER;
      INSTR_JAL, INSTR_JALR:
        instr_class = TC_JUMP;
      INSTR_BEQ, INSTR_BNE, INSTR_BEQIMM, INSTR_BNEIMM,
      INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU:
        instr_class = TC_BRANCH;
      INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU:
        instr_class = TC_LOAD;
      INSTR_SB, INSTR_SH, INSTR_SW:
        instr_class = TC_STORE;
      INSTR_MUL, INSTR_MULH, INSTR_MULHSU, INSTR_MULHU,
      INSTR_DIV, INSTR_DIVU, INSTR_REM, INSTR_REMU,
      INSTR_PMAC, INSTR_PMSU:
        instr_class = TC_MULDIV;
      INSTR_FF1, INSTR_FL1, INSTR_CLB, INSTR_CNT,
      INSTR_EXTHS, INSTR_EXTHZ, INSTR_EXTBS, INSTR_EXTBZ,
      INSTR_PAVG, INSTR_PAVGU, INSTR_PSLET, INSTR_PSLETU,
      INSTR_PMIN, INSTR_PMINU, INSTR_PMAX, INSTR_PMAXU,
      INSTR_ROR, INSTR_PABS, INSTR_CLIP, INSTR_CLIPU,
      INSTR_PBEXT, INSTR_PBEXTU, INSTR_PBINS, INSTR_PBCLR, INSTR_PBSET,
      INSTR_PBEXTR, INSTR_PBEXTUR, INSTR_PBINSR, INSTR_PBCLRR, INSTR_PBSETR:
        instr_class = TC_PULP_ALU;
      INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU,
      INSTR_XOR, INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND,
      INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI,
      INSTR_ANDI, INSTR_SLLI, INSTR_SRLI, INSTR_SRAI:
        instr_class = TC_ALU;
      INSTR_CSRRW, INSTR_CSRRS, INSTR_CSRRC,
      INSTR_CSRRWI, INSTR_CSRRSI, INSTR_CSRRCI:
        instr_class = TC_CSR;
      INSTR_ECALL, INSTR_EBREAK, INSTR_URET, INSTR_MRET, INSTR_DRET, INSTR_WFI:
        instr_class = TC_SYSTEM;
      INSTR_FENCE, INSTR_FENCEI:
        instr_class = TC_FENCE;
      INSTR_FLW, INSTR_FSW, INSTR_FMADD, INSTR_FMSUB,
      INSTR_FNMSUB, INSTR_FNMADD, INSTR_FOP_S:
        instr_class = TC_FP;
      INSTR_LR, INSTR_SC, INSTR_AMOSWAP, INSTR_AMOADD, INSTR_AMOXOR,
      INSTR_AMOAND, INSTR_AMOOR, INSTR_AMOMIN, INSTR_AMOMAX,
      INSTR_AMOMINU, INSTR_AMOMAXU:
        instr_class = TC_ATOMIC;
      default:
        instr_class = TC_NONE;
    endcase
  end

endmodule

// File: rtl/riscv_trace_collector.sv
// Retire-point capture stage: classifies each retired record, buffers it in a
// small FIFO and streams it to the tracer; overflow drops and counts records.
module riscv_trace_collector
  import riscv_tracer_defines::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic                     ret_valid_i,
  input  logic [31:0]              ret_pc_i,
  input  logic [31:0]              ret_instr_i,
  input  logic                     ret_compressed_i,
  input  logic                     ret_rd_we_i,
  input  logic [5:0]               ret_rd_addr_i,
  input  logic [31:0]              ret_rd_wdata_i,
  output logic                     trc_valid_o,
  input  logic                     trc_ready_i,
  output logic [31:0]              trc_pc_o,
  output logic [31:0]              trc_instr_o,
  output logic                     trc_compressed_o,
  output logic [3:0]               trc_class_o,
  output logic                     trc_rd_we_o,
  output logic [5:0]               trc_rd_addr_o,
  output logic [31:0]              trc_rd_wdata_o,
  output logic [CNT_WIDTH-1:0]     trc_seq_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     overflow_o,
  output logic [CNT_WIDTH-1:0]     drop_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  trace_rec_t           mem [DEPTH];
  trace_rec_t           in_rec;
  trace_rec_t           head;
  trace_class_e         in_class;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          fill;
  logic [CNT_WIDTH-1:0] seq;
  logic [CNT_WIDTH-1:0] drop_cnt;
  logic                 overflow;
  logic                 empty;
  logic                 full;
  logic                 capture;
  logic                 pop;
  logic                 push;
  logic                 drop;

  riscv_trace_classify u_classify (
    .instr       (ret_instr_i),
    .instr_class (in_class)
  );

  // Clear suppresses capture, so a record arriving with clear is never counted.
  always_comb begin
    empty   = (fill == '0);
    full    = (fill == (AW+1)'(DEPTH));
    capture = ret_valid_i & enable_i & ~clear_i;
    pop     = ~empty & trc_ready_i & ~clear_i;
    push    = capture & (~full | pop);
    drop    = capture & ~push;

    in_rec             = '0;
    in_rec.pc          = ret_pc_i;
    in_rec.instr       = ret_instr_i;
    in_rec.compressed  = ret_compressed_i;
    in_rec.instr_class = in_class;
    in_rec.rd_we       = ret_rd_we_i;
    in_rec.rd_addr     = ret_rd_addr_i;
    in_rec.rd_wdata    = ret_rd_wdata_i;
    in_rec.seq         = TRACE_SEQ_W'(seq);

    // Storage is not reset; an empty FIFO presents all-zero data instead.
    head = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= in_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      seq      <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fill <= fill + 1'b1;
      end else if (pop && !push) begin
        fill <= fill - 1'b1;
      end
      if (capture) begin
        seq <= seq + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    trc_valid_o      = ~empty;
    trc_pc_o         = head.pc;
    trc_instr_o      = head.instr;
    trc_compressed_o = head.compressed;
    trc_class_o      = head.instr_class;
    trc_rd_we_o      = head.rd_we;
    trc_rd_addr_o    = head.rd_addr;
    trc_rd_wdata_o   = head.rd_wdata;
    trc_seq_o        = CNT_WIDTH'(head.seq);
    fill_o           = fill;
    overflow_o       = overflow;
    drop_cnt_o       = drop_cnt;
  end

endmodule
